countdown_display_ctrl: RTL and testbench

//  Sequencer for the hex countdown counter and 7-segment display path.

---
 rtl/countdown_display_if.sv | 31 +++
 rtl/countdown_display_ctrl.sv | 150 +++++++++++++++
 tb/tb_countdown_display_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_display_if.sv
// rtl/countdown_display_if.sv - control/status bundle between board I/O and the countdown sequencer
//
// Ports (interface signals):
//   start, pause, load   level inputs toward the sequencer
//   load_value [WIDTH]   value captured on load
//   count [WIDTH]        registered counter value
//   display_segment [7]  registered active-low segments {g,f,e,d,c,b,a}
//   busy, done           registered status
// Modports: master drives the controls; slave is the sequencer side.
interface countdown_display_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic [6:0]       display_segment;
    logic             busy;
    logic             done;

    modport master (
        output start, pause, load, load_value,
        input  count, display_segment, busy, done
    );

    modport slave (
        input  start, pause, load, load_value,
        output count, display_segment, busy, done
    );
endinterface

// File: rtl/countdown_display_ctrl.sv
// rtl/countdown_display_ctrl.sv - hex down-counter sequencer with prescaler and registered 7-segment decode
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    countdown_display_if.slave:
//            start/pause/load/load_value in, count/display_segment/busy/done out
// Parameters:
//   WIDTH       counter width; the display shows the low 4 bits
//   TICK_DIV    clk cycles per decrement (>= 1)
//   INIT_VALUE  count after reset and after start-from-DONE
module countdown_display_ctrl #(
    parameter int WIDTH      = 4,
    parameter int TICK_DIV   = 10,
    parameter int INIT_VALUE = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    countdown_display_if.slave   bus
);

    // Prescaler needs at least one bit even when TICK_DIV == 1.
    localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] INIT_CNT  = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] ONE_CNT   = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [6:0]       seg_q,   seg_d;

    // Active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    count_d = bus.load_value;
                end else if (bus.start) begin
                    // Starting from zero goes straight to DONE without a tick.
                    if (count_q != '0) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // Pause beats a tick landing on the same cycle.
                if (bus.pause) begin
                    state_d = S_PAUSE;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    count_d = count_q - ONE_CNT;
                    // RUN is only ever entered with a non-zero count, so the
                    // last decrement is always from 1 and the count cannot wrap.
                    if (count_q == ONE_CNT) begin
                        state_d = S_DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                // Prescaler is held so the interrupted period resumes where it left off.
                if (!bus.pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.load) begin
                    state_d = S_IDLE;
                    count_d = bus.load_value;
                end else if (bus.start) begin
                    state_d = S_IDLE;
                    count_d = INIT_CNT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
        // Decoding the current register gives the one-cycle display lag.
        seg_d  = hex_to_seg(4'(count_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= INIT_CNT;
            presc_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= hex_to_seg(4'(INIT_CNT));
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.count           = count_q;
    assign bus.display_segment = seg_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_countdown_display_ctrl.sv
// tb/tb_countdown_display_ctrl.sv - self-checking bench for countdown_display_ctrl (TICK_DIV 10 and 1)
module tb_countdown_display_ctrl;

    localparam int WIDTH = 4;
    localparam int INIT  = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    countdown_display_if #(.WIDTH(WIDTH)) bus10();
    countdown_display_if #(.WIDTH(WIDTH)) bus1();

    countdown_display_ctrl #(.WIDTH(WIDTH), .TICK_DIV(10), .INIT_VALUE(INIT)) u_dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus10)
    );

    countdown_display_ctrl #(.WIDTH(WIDTH), .TICK_DIV(1), .INIT_VALUE(INIT)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    function automatic logic [6:0] seg_of(input int v);
        case (v & 15)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Behavioural model: mode 0 idle, 1 counting, 2 paused, 3 finished.
    // 'elapsed' counts clocks spent counting in the current tick period.
    typedef struct {
        int mode;
        int count;
        int elapsed;
        int shown;
        bit busy;
        bit done;
    } model_t;

    model_t m10 = '{0, INIT, 0, INIT, 1'b0, 1'b0};
    model_t m1  = '{0, INIT, 0, INIT, 1'b0, 1'b0};

    function automatic model_t model_step(model_t m, bit r, bit s, bit p, bit l, int lv, int div);
        model_t n = m;
        if (r) begin
            n = '{0, INIT, 0, INIT, 1'b0, 1'b0};
            return n;
        end
        n.shown = m.count;
        case (m.mode)
            0: begin
                if (l) n.count = lv;
                else if (s) begin
                    if (m.count > 0) begin n.mode = 1; n.elapsed = 0; end
                    else n.mode = 3;
                end
            end
            1: begin
                if (p) n.mode = 2;
                else begin
                    n.elapsed = m.elapsed + 1;
                    if (n.elapsed == div) begin
                        n.elapsed = 0;
                        n.count = m.count - 1;
                        if (n.count == 0) n.mode = 3;
                    end
                end
            end
            2: if (!p) n.mode = 1;
            default: begin
                if (l)      begin n.mode = 0; n.count = lv;   end
                else if (s) begin n.mode = 0; n.count = INIT; end
            end
        endcase
        n.busy = (n.mode == 1) || (n.mode == 2);
        n.done = (n.mode == 3) && (m.mode != 3);
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic check_model(input string name, input model_t m, input logic [3:0] c,
                               input logic [6:0] sg, input logic b, input logic d);
        vectors++;
        if (c !== 4'(m.count) || sg !== seg_of(m.shown) || b !== m.busy || d !== m.done) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got count=%0d seg=%b busy=%b done=%b expected count=%0d seg=%b busy=%b done=%b",
                     name, cyc, c, sg, b, d, m.count, seg_of(m.shown), m.busy, m.done);
        end
    endtask

    // One clock: drive inputs, advance models at the edge, compare #1 later.
    task automatic cycle(input bit r, input bit s, input bit p, input bit l, input int lv);
        reset            = r;
        bus10.start      = s;  bus1.start      = s;
        bus10.pause      = p;  bus1.pause      = p;
        bus10.load       = l;  bus1.load       = l;
        bus10.load_value = 4'(lv); bus1.load_value = 4'(lv);
        @(posedge clk);
        cyc++;
        m10 = model_step(m10, r, s, p, l, lv, 10);
        m1  = model_step(m1,  r, s, p, l, lv, 1);
        #1;
        check_model("model_div10", m10, bus10.count, bus10.display_segment, bus10.busy, bus10.done);
        check_model("model_div1",  m1,  bus1.count,  bus1.display_segment,  bus1.busy,  bus1.done);
    endtask

    typedef struct {
        bit         r, s, p, l;
        int         lv;
        int         e_count;
        bit         e_busy;
        bit         e_done;
        logic [6:0] e_seg;
    } vec_t;

    vec_t tab[14];

    initial begin
        int first14, d10, d1, dcnt, busy_drop, n;

        // Expected values for the TICK_DIV=10 instance, written from the rules.
        tab[0]  = '{1, 0, 0, 0, 0, 15, 0, 0, 7'b0001110};
        tab[1]  = '{0, 1, 0, 1, 9,  9, 0, 0, 7'b0001110};
        tab[2]  = '{0, 0, 0, 0, 0,  9, 0, 0, 7'b0010000};
        tab[3]  = '{0, 1, 0, 1, 4,  4, 0, 0, 7'b0010000};
        tab[4]  = '{0, 0, 0, 0, 0,  4, 0, 0, 7'b0011001};
        tab[5]  = '{0, 0, 0, 1, 0,  0, 0, 0, 7'b0011001};
        tab[6]  = '{0, 1, 0, 0, 0,  0, 0, 1, 7'b1000000};
        tab[7]  = '{0, 0, 0, 0, 0,  0, 0, 0, 7'b1000000};
        tab[8]  = '{0, 1, 0, 0, 0, 15, 0, 0, 7'b1000000};
        tab[9]  = '{0, 0, 0, 0, 0, 15, 0, 0, 7'b0001110};
        tab[10] = '{0, 1, 0, 0, 0, 15, 1, 0, 7'b0001110};
        tab[11] = '{0, 0, 1, 0, 0, 15, 1, 0, 7'b0001110};
        tab[12] = '{0, 0, 0, 0, 0, 15, 1, 0, 7'b0001110};
        tab[13] = '{1, 0, 0, 0, 0, 15, 0, 0, 7'b0001110};

        bus10.start = 0; bus10.pause = 0; bus10.load = 0; bus10.load_value = '0;
        bus1.start  = 0; bus1.pause  = 0; bus1.load  = 0; bus1.load_value  = '0;

        for (int i = 0; i < 14; i++) begin
            cycle(tab[i].r, tab[i].s, tab[i].p, tab[i].l, tab[i].lv);
            check($sformatf("tab%0d_count", i), bus10.count, tab[i].e_count);
            check($sformatf("tab%0d_busy", i),  bus10.busy,  tab[i].e_busy);
            check($sformatf("tab%0d_done", i),  bus10.done,  tab[i].e_done);
            check($sformatf("tab%0d_seg", i),   bus10.display_segment, tab[i].e_seg);
        end

        // Full countdown from INIT; the TICK_DIV=1 instance runs alongside.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("t1_busy_after_start", bus10.busy, 1);
        first14 = 0; d10 = 0; d1 = 0; dcnt = 0;
        for (int k = 1; k <= 200; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (first14 == 0 && bus10.count == 4'd14) first14 = k;
            if (bus10.done) begin dcnt++; if (d10 == 0) d10 = k; end
            if (d1 == 0 && bus1.done) d1 = k;
            if (d10 != 0 && k >= d10 + 5) break;
        end
        check("t1_first_tick", first14, 10);
        check("t1_done_cycle", d10, 150);
        check("t1_done_pulses", dcnt, 1);
        check("t1_final_count", bus10.count, 0);
        check("t1_seg_zero", bus10.display_segment, 7'b1000000);
        check("t6_div1_done_cycle", d1, 15);

        // Load 9 then start: 90 cycles, busy throughout.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 9);
        cycle(0, 1, 0, 0, 0);
        d10 = 0; dcnt = 0; busy_drop = 0;
        for (int k = 1; k <= 120; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (busy_drop == 0 && !bus10.busy) busy_drop = k;
            if (bus10.done) begin dcnt++; if (d10 == 0) d10 = k; end
            if (d10 != 0 && k >= d10 + 3) break;
        end
        check("t2_done_cycle", d10, 90);
        check("t2_busy_drop", busy_drop, 90);
        check("t2_done_pulses", dcnt, 1);

        // Pause 3 cycles into a period at count 7.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 83; k++) cycle(0, 0, 0, 0, 0);
        check("t3_count_before_pause", bus10.count, 7);
        for (int k = 0; k < 25; k++) cycle(0, 0, 1, 0, 0);
        check("t3_count_paused", bus10.count, 7);
        check("t3_busy_paused", bus10.busy, 1);
        cycle(0, 0, 0, 0, 0);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (bus10.count == 4'd6) begin n = k; break; end
        end
        check("t3_resume_tick", n, 7);

        // Reset while running at count 5.
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (bus10.count == 4'd5) begin n = k; break; end
        end
        check("t5_reach_5", n, 10);
        cycle(1, 0, 0, 0, 0);
        check("t5_count", bus10.count, 15);
        check("t5_busy", bus10.busy, 0);
        cycle(0, 0, 0, 0, 0);
        check("t5_seg", bus10.display_segment, 7'b0001110);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
